gf163_reduce_seq: RTL and testbench

GF163_REDUCE_SEQ -- requirements
Module: gf163_reduce_seq

---
 rtl/gf163_reduce_seq.sv | 144 ++++++++++++++
 tb/tb_gf163_reduce_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf163_reduce_seq.sv
// ---------------------------------------------------------------------------
// gf163_reduce_seq
//
// Purpose:
//   Sequential reduction of an unreduced 325-bit polynomial product modulo
//   the GF(2^163) field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1.
//   A product is captured into a work register and folded downward one
//   chunk per cycle, six chunks in total, after which the low 163 bits
//   hold the remainder.
//
// Ports:
//   clk        in   1    clock, rising-edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    in_prod holds a product to reduce
//   in_ready   out  1    block accepts a product this cycle (IDLE only)
//   in_prod    in   325  unreduced product, bit i = coefficient of x^i
//   clr        in   1    synchronous abort, wins over in_valid/out_ready
//   out_valid  out  1    out_rem holds the reduced result (DONE only)
//   out_ready  in   1    consumer takes out_rem this cycle
//   out_rem    out  163  in_prod mod f(x); zero whenever out_valid is low
//   busy       out  1    high while folding or holding a result
// ---------------------------------------------------------------------------
module gf163_reduce_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [324:0] in_prod,
    input  logic         clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [162:0] out_rem,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [324:0]   r_work;
    logic [324:0]   w_workNext;
    logic [2:0]     r_cnt;
    logic [2:0]     w_cntNext;

    logic [324:0]   w_chunkMask;
    logic [324:0]   w_chunk;
    logic [324:0]   w_folded;

    // Select the slice of W folded this cycle. The top chunk is folded
    // first; its images land as high as bit 168, inside chunk 4, and bits
    // 164/163 are only cleared by the final two-bit chunk.
    always_comb begin
        w_chunkMask = '0;
        case (r_cnt)
            3'd0: w_chunkMask = {{32{1'b1}}, {293{1'b0}}};
            3'd1: w_chunkMask = {{32{1'b0}}, {32{1'b1}}, {261{1'b0}}};
            3'd2: w_chunkMask = {{64{1'b0}}, {32{1'b1}}, {229{1'b0}}};
            3'd3: w_chunkMask = {{96{1'b0}}, {32{1'b1}}, {197{1'b0}}};
            3'd4: w_chunkMask = {{128{1'b0}}, {32{1'b1}}, {165{1'b0}}};
            3'd5: w_chunkMask = {{160{1'b0}}, 2'b11, {163{1'b0}}};
            default: w_chunkMask = '0;
        endcase
    end

    // x^j = x^(j-163) * (x^7 + x^6 + x^3 + 1), so every set bit of the chunk
    // is cleared and XOR-ed back at offsets -156, -157, -160 and -163. All
    // targets lie strictly below the chunk, so the whole chunk folds in one
    // cycle from the start-of-cycle value of W.
    assign w_chunk  = r_work & w_chunkMask;
    assign w_folded = (r_work ^ w_chunk)
                    ^ (w_chunk >> 156)
                    ^ (w_chunk >> 157)
                    ^ (w_chunk >> 160)
                    ^ (w_chunk >> 163);

    // Next-state and datapath update. clr overrides everything and discards
    // the work register. The handoff edge in DONE only returns to IDLE, so a
    // new product can be taken at the earliest on the following edge.
    always_comb begin
        w_stateNext = r_state;
        w_workNext  = r_work;
        w_cntNext   = r_cnt;
        if (clr) begin
            w_stateNext = IDLE;
            w_workNext  = '0;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_stateNext = FOLD;
                        w_workNext  = in_prod;
                        w_cntNext   = '0;
                    end
                end
                FOLD: begin
                    w_workNext = w_folded;
                    if (r_cnt == 3'd5) begin
                        w_stateNext = DONE;
                    end else begin
                        w_cntNext = r_cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_stateNext = IDLE;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_workNext  = '0;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    // State, work register and fold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_work  <= w_workNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Handshake outputs decode directly from the state register; the
    // remainder is gated so it reads zero outside DONE.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
        out_rem   = (r_state == DONE) ? r_work[162:0] : '0;
    end

endmodule

// File: tb/tb_gf163_reduce_seq.sv
module tb_gf163_reduce_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [324:0] in_prod;
    logic         clr;
    logic         out_valid;
    logic         out_ready;
    logic [162:0] out_rem;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [324:0] POLY = {161'b0, 1'b1, 155'b0, 8'hC9};

    gf163_reduce_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial long division by f(x), independent of the chunked hardware.
    function automatic logic [162:0] refMod(input logic [324:0] p);
        logic [324:0] t;
        t = p;
        for (int i = 324; i >= 163; i--) begin
            if (t[i]) t = t ^ (POLY << (i - 163));
        end
        return t[162:0];
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present one product, then count edges to out_valid.
    task automatic doOp(input logic [324:0] prod, output logic [162:0] rem,
                        output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_prod  = prod;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rem = out_rem;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [162:0] rem;
        int lat;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_prod  = 325'd1 << 163;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_rem !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got ready=%b busy=%b valid=%b rem=%h expected 1 0 0 0",
                     in_ready, busy, out_valid, out_rem);
        end
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_accept: got busy=%b expected 1", busy);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rem = out_rem;
        checks++;
        if (lat !== 6) begin
            failures++;
            $display("[TB] FAIL latency_x163: got %0d expected 6", lat);
        end
        checks++;
        if (rem !== 163'hC9) begin
            failures++;
            $display("[TB] FAIL rem_x163: got %h expected %h", rem, 163'hC9);
        end
        handoff();
    endtask

    task automatic test_vectors();
        logic [324:0] prods [4];
        logic [162:0] exps  [4];
        logic [162:0] rem;
        int lat;
        prods[0] = 325'd1 << 164;
        exps[0]  = 163'h192;
        prods[1] = POLY;
        exps[1]  = '0;
        prods[2] = {162'b0, 3'b101, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0,
                    32'h0F1E2D3C, 32'hA5A55A5A};
        exps[2]  = {3'b101, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0,
                    32'h0F1E2D3C, 32'hA5A55A5A};
        prods[3] = 325'd1 << 324;
        exps[3]  = (163'd1 << 161) | 163'h1422;
        for (int i = 0; i < 4; i++) begin
            doOp(prods[i], rem, lat);
            checks++;
            if (rem !== exps[i]) begin
                failures++;
                $display("[TB] FAIL vector%0d_rem: got %h expected %h", i, rem, exps[i]);
            end
            checks++;
            if (lat !== 6) begin
                failures++;
                $display("[TB] FAIL vector%0d_latency: got %0d expected 6", i, lat);
            end
            handoff();
        end
    endtask

    task automatic test_hold();
        logic [162:0] rem;
        int lat;
        doOp(325'd1 << 164, rem, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_rem !== 163'h192 || in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b rem=%h expected 1 0 %h",
                         i, out_valid, in_ready, out_rem, 163'h192);
            end
        end
        handoff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rem !== '0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_release: got ready=%b valid=%b busy=%b rem=%h expected 1 0 0 0",
                     in_ready, out_valid, busy, out_rem);
        end
    endtask

    task automatic test_back_to_back();
        logic [162:0] rem;
        int lat;
        doOp(325'd1 << 163, rem, lat);
        in_valid  = 1'b1;
        in_prod   = 325'd1 << 164;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL handoff_no_accept: got busy=%b ready=%b expected 0 1", busy, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accept_after_handoff: got busy=%b expected 1", busy);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (out_rem !== 163'h192 || lat !== 6) begin
            failures++;
            $display("[TB] FAIL back_to_back_result: got rem=%h lat=%0d expected %h 6",
                     out_rem, lat, 163'h192);
        end
        handoff();
    endtask

    task automatic test_reset_midop();
        logic [162:0] rem;
        int lat;
        in_valid = 1'b1;
        in_prod  = 325'd1 << 324;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_rem !== '0) begin
            failures++;
            $display("[TB] FAIL midop_reset: got ready=%b busy=%b valid=%b rem=%h expected 1 0 0 0",
                     in_ready, busy, out_valid, out_rem);
        end
        #2;
        rst_n = 1'b1;
        doOp(325'd1 << 163, rem, lat);
        checks++;
        if (rem !== 163'hC9 || lat !== 6) begin
            failures++;
            $display("[TB] FAIL after_reset_result: got rem=%h lat=%0d expected %h 6", rem, lat, 163'hC9);
        end
        handoff();
    endtask

    task automatic test_clr();
        int lat;
        in_valid = 1'b1;
        in_prod  = 325'd1 << 324;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 325'd1 << 164;
        tick();
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_rem !== '0) begin
            failures++;
            $display("[TB] FAIL clr_midop: got busy=%b ready=%b valid=%b rem=%h expected 0 1 0 0",
                     busy, in_ready, out_valid, out_rem);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_over_in_valid: got busy=%b expected 0", busy);
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (out_rem !== 163'h192 || lat !== 6) begin
            failures++;
            $display("[TB] FAIL after_clr_result: got rem=%h lat=%0d expected %h 6",
                     out_rem, lat, 163'h192);
        end
        clr       = 1'b1;
        out_ready = 1'b1;
        tick();
        clr       = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clr_in_done: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [351:0] raw;
        logic [324:0] prod;
        logic [162:0] rem;
        logic [162:0] exp;
        int lat;
        for (int n = 0; n < 200; n++) begin
            raw = '0;
            for (int w = 0; w < 11; w++) raw = {raw[319:0], $urandom()};
            prod = raw[324:0];
            exp  = refMod(prod);
            doOp(prod, rem, lat);
            checks++;
            if (rem !== exp || lat !== 6) begin
                failures++;
                $display("[TB] FAIL random%0d: got rem=%h lat=%0d expected %h 6", n, rem, lat, exp);
            end
            handoff();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        clr       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_reset_midop();
        test_clr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
